// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, single-outstanding imem request,
// 2-entry {pc, word} buffer toward the datapath, and redirect with stale-response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {StReq, StWait, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] tag_pc_q, tag_pc_d;
  logic [31:0] buf_pc_q   [2];
  logic [31:0] buf_word_q [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        accept;
  logic        push;
  logic        pop;

  // Gated by rst_n so no request is presented while reset is held.
  assign imem_req    = rst_n && (state_q == StReq) && (count_q != 2'd2);
  assign imem_addr   = fetch_pc_q;
  assign accept      = imem_req && imem_ready;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = buf_word_q[rd_ptr_q];
  assign instr_pc    = buf_pc_q[rd_ptr_q];
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    push       = 1'b0;

    case (state_q)
      StReq: begin
        if (accept) begin
          tag_pc_d = fetch_pc_q;
          state_d  = redirect ? StDiscard : StWait;
        end
      end
      StWait: begin
        // A response that lands with a redirect is stale; it still retires the request.
        if (imem_rvalid) begin
          push    = !redirect;
          state_d = StReq;
        end else if (redirect) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_rvalid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]   <= '0;
        buf_word_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        buf_pc_q[wr_ptr_q]   <= tag_pc_q;
        buf_word_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency/readiness and an
// instruction-stream reference (expected pc advances by 4, jumps on redirect).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int n_pop = 0;
  int n_acc = 0;

  bit          ready_rand = 1'b0;
  bit          lat_rand = 1'b0;
  int unsigned mem_lat = 1;
  int unsigned cyc = 0;

  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  bit          acc_q = 1'b0;
  logic [31:0] acc_addr = '0;
  int unsigned acc_lat = 1;
  logic [31:0] exp_pc = RESET_PC;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: runs after stimulus (+1) each cycle, drives for the next rising edge.
  always @(negedge clk) begin
    #3;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      acc_q = 1'b0;
      n_acc = 0;
      imem_rvalid = 1'b0;
      imem_ready = 1'b1;
    end else begin
      if (imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (acc_q) begin
        pend_addr.push_back(acc_addr);
        pend_due.push_back(cyc + acc_lat);
        n_acc++;
      end
      imem_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      acc_q    = imem_req && imem_ready;
      acc_addr = imem_addr;
      acc_lat  = lat_rand ? $urandom_range(1, 3) : mem_lat;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memword(pend_addr[0]);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
  end

  // Stream reference: values seen here are those the next rising edge samples.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      exp_pc = RESET_PC;
    end else begin
      if (instr_valid && instr_ready) begin
        total++;
        n_pop++;
        if (instr_pc !== exp_pc || instr !== memword(exp_pc)) begin
          bad++;
          $display("FAIL stream: got pc=%h instr=%h, want pc=%h instr=%h",
                   instr_pc, instr, exp_pc, memword(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
      total++;
      if (imem_req && (pend_addr.size() != 0 || imem_addr[1:0] != 2'b00)) begin
        bad++;
        $display("FAIL issue: req with outstanding=%0d addr=%h, want none outstanding, aligned",
                 pend_addr.size(), imem_addr);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst_n = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // kind 0: request to addr; 1: any request; 2: instr_valid.
  task automatic wait_for(input int kind, input logic [31:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((kind == 0 && imem_req && imem_addr == addr) || (kind == 1 && imem_req) ||
          (kind == 2 && instr_valid)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    tick();
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h, want all zero",
               imem_req, instr_valid, instr, instr_pc);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential;
    reset_dut();
    instr_ready = 1'b1;
    mem_lat = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (instr_valid !== (k % 2 == 0)) begin
        bad++;
        $display("FAIL seq_valid[%0d]: got %b want %b", k, instr_valid, (k % 2 == 0));
      end else if (k % 2 == 0) begin
        total++;
        if (instr_pc !== 32'((k / 2 - 1) * 4) || instr !== memword(32'((k / 2 - 1) * 4))) begin
          bad++;
          $display("FAIL seq_entry[%0d]: got pc=%h instr=%h want pc=%h", k, instr_pc, instr,
                   32'((k / 2 - 1) * 4));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    reset_dut();
    instr_ready = 1'b0;
    repeat (8) tick();
    total++;
    if (n_acc != 2 || imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL bp_full: accepts=%0d req=%b valid=%b pc=%h, want 2 0 1 0",
               n_acc, imem_req, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      bad++;
      $display("FAIL bp_drain: valid=%b pc=%h req=%b addr=%h, want 1 4 1 8",
               instr_valid, instr_pc, imem_req, imem_addr);
    end
    instr_ready = 1'b1;
  endtask

  task automatic test_redirect_wait;
    bit ok;
    reset_dut();
    mem_lat = 2;
    instr_ready = 1'b1;
    wait_for(0, 32'h8, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rw_reach8: req for 8 not seen, want seen"); end
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rw_discard: req=%b valid=%b, want 0 0", imem_req, instr_valid);
    end
    wait_for(1, 32'h0, ok);
    total++;
    if (!ok || imem_addr !== 32'h0000_0100 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rw_target: seen=%b addr=%h valid=%b, want 1 00000100 0",
               ok, imem_addr, instr_valid);
    end
    wait_for(2, 32'h0, ok);
    total++;
    if (!ok || instr_pc !== 32'h100 || instr !== memword(32'h100)) begin
      bad++;
      $display("FAIL rw_first_instr: seen=%b pc=%h instr=%h, want pc 00000100", ok, instr_pc, instr);
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_pop_rvalid;
    bit ok;
    reset_dut();
    mem_lat = 1;
    instr_ready = 1'b0;
    wait_for(0, 32'h4, ok);
    tick();
    total++;
    if (!ok || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL rpr_setup: seen=%b valid=%b pc=%h, want 1 1 0", ok, instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++;
      $display("FAIL rpr_flush: valid=%b req=%b addr=%h, want 0 1 00000040",
               instr_valid, imem_req, imem_addr);
    end
    wait_for(2, 32'h0, ok);
    total++;
    if (!ok || instr_pc !== 32'h40) begin
      bad++;
      $display("FAIL rpr_first_instr: seen=%b pc=%h, want 00000040", ok, instr_pc);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    reset_dut();
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    wait_for(1, 32'h0, ok);
    total++;
    if (!ok || imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_top: seen=%b addr=%h, want FFFFFFFC", ok, imem_addr);
    end
    tick();
    wait_for(1, 32'h0, ok);
    total++;
    if (!ok || imem_addr !== 32'h0 || instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_next: seen=%b addr=%h valid=%b pc=%h, want 0 1 FFFFFFFC",
               ok, imem_addr, instr_valid, instr_pc);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    reset_dut();
    mem_lat = 3;
    instr_ready = 1'b0;
    wait_for(0, 32'h4, ok);
    tick();
    total++;
    if (!ok || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rm_setup: seen=%b valid=%b req=%b, want 1 1 0", ok, instr_valid, imem_req);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rm_async: valid=%b req=%b, want 0 0", instr_valid, imem_req);
    end
    tick();
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_release: req=%b addr=%h valid=%b, want 1 %h 0",
               imem_req, imem_addr, instr_valid, RESET_PC);
    end
    mem_lat = 1;
  endtask

  task automatic test_random;
    int pops0;
    reset_dut();
    ready_rand = 1'b1;
    lat_rand = 1'b1;
    pops0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
    end
    tick();
    redirect = 1'b0;
    total++;
    if (n_pop - pops0 < 200) begin
      bad++;
      $display("FAIL random_progress: pops=%0d, want >= 200", n_pop - pops0);
    end
    ready_rand = 1'b0;
    lat_rand = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_pop_rvalid();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
